// File: rtl/bp_be_issue_queue.sv
// Speculative issue buffer: circular buffer with write, speculative-issue and commit pointers.
// Optional same-cycle enqueue-to-issue bypass under BP_BE_ISSUE_QUEUE_BYPASS_EN.
module bp_be_issue_queue #(
  parameter int  els_p        = 8,
  parameter int  data_width_p = 128,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enq_v_i,
  input  logic [data_width_p-1:0] enq_data_i,
  output logic                    enq_ready_o,
  output logic                    issue_v_o,
  output logic [data_width_p-1:0] issue_data_o,
  input  logic                    issue_yumi_i,
  input  logic                    cmt_v_i,
  input  logic                    roll_v_i,
  input  logic                    clr_v_i,
  output logic [ptr_width_lp-1:0] issued_cnt_o,
  output logic [ptr_width_lp-1:0] total_cnt_o
);

  localparam int                    idx_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp-1:0] one_lp     = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] els_lp     = ptr_width_lp'(els_p);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;

  logic full, issue_empty, enq_fire, issue_fire, cmt_fire;

  assign total_cnt_o  = wptr_q - cptr_q;
  assign issued_cnt_o = rptr_q - cptr_q;
  assign full         = (total_cnt_o == els_lp);
  assign issue_empty  = (rptr_q == wptr_q);
  assign enq_ready_o  = ~full;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  logic bypass_v;
  assign bypass_v     = issue_empty & enq_v_i & enq_ready_o;
  assign issue_v_o    = ~issue_empty | bypass_v;
  assign issue_data_o = bypass_v ? enq_data_i : mem_q[rptr_q[idx_width_lp-1:0]];
`else
  assign issue_v_o    = ~issue_empty;
  assign issue_data_o = mem_q[rptr_q[idx_width_lp-1:0]];
`endif

  assign enq_fire   = enq_v_i & enq_ready_o & ~clr_v_i;
  assign issue_fire = issue_yumi_i & issue_v_o & ~roll_v_i & ~clr_v_i;
  assign cmt_fire   = cmt_v_i & (cptr_q != rptr_q) & ~clr_v_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_v_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + one_lp;
      if (cmt_fire) cptr_d = cptr_q + one_lp;
      // Rollback targets the post-commit pointer so a same-cycle retire is not replayed.
      if (roll_v_i)        rptr_d = cptr_d;
      else if (issue_fire) rptr_d = rptr_q + one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[wptr_q[idx_width_lp-1:0]] <= enq_data_i;
  end

`ifndef SYNTHESIS
  yumi_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    issue_yumi_i |-> issue_v_o);
  cmt_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cmt_v_i |-> (cptr_q != rptr_q));
  ptr_order_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (issued_cnt_o <= total_cnt_o) && (total_cnt_o <= els_lp));
`endif

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue (els_p=4, 8-bit payload).
module tb_bp_be_issue_queue;

  localparam int ELS = 4;
  localparam int DW  = 8;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          enq_v_i;
  logic [DW-1:0] enq_data_i;
  logic          enq_ready_o;
  logic          issue_v_o;
  logic [DW-1:0] issue_data_o;
  logic          issue_yumi_i;
  logic          cmt_v_i;
  logic          roll_v_i;
  logic          clr_v_i;
  logic [PW-1:0] issued_cnt_o;
  logic [PW-1:0] total_cnt_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bp_be_issue_queue #(.els_p(ELS), .data_width_p(DW)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .enq_v_i     (enq_v_i),
    .enq_data_i  (enq_data_i),
    .enq_ready_o (enq_ready_o),
    .issue_v_o   (issue_v_o),
    .issue_data_o(issue_data_o),
    .issue_yumi_i(issue_yumi_i),
    .cmt_v_i     (cmt_v_i),
    .roll_v_i    (roll_v_i),
    .clr_v_i     (clr_v_i),
    .issued_cnt_o(issued_cnt_o),
    .total_cnt_o (total_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    enq_v_i = 1'b0; enq_data_i = '0; issue_yumi_i = 1'b0;
    cmt_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic [DW-1:0] d);
    idle(); enq_v_i = 1'b1; enq_data_i = d; cyc(); idle();
  endtask

  task automatic clear();
    idle(); clr_v_i = 1'b1; cyc(); idle();
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle();
    #3;
    chk("rst_ready", enq_ready_o, 1);
    chk("rst_issue_v", issue_v_o, 0);
    chk("rst_issued", issued_cnt_o, 0);
    chk("rst_total", total_cnt_o, 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // three enqueues, then issue them
    idle(); enq_v_i = 1'b1; enq_data_i = 8'h0A; #1;
`ifndef BP_BE_ISSUE_QUEUE_BYPASS_EN
    chk("t1_no_bypass", issue_v_o, 0);
`endif
    cyc();
    chk("t1_lat_v", issue_v_o, 1);
    chk("t1_lat_d", issue_data_o, 8'h0A);
    enq(8'h0B); enq(8'h0C);
    chk("t1_total_pre", total_cnt_o, 3);
    chk("t1_issued_pre", issued_cnt_o, 0);
    issue_yumi_i = 1'b1; chk("t1_iss0", issue_data_o, 8'h0A); cyc();
    chk("t1_iss1", issue_data_o, 8'h0B); cyc();
    chk("t1_iss2", issue_data_o, 8'h0C); cyc();
    idle();
    chk("t1_issued", issued_cnt_o, 3);
    chk("t1_total", total_cnt_o, 3);
    chk("t1_empty", issue_v_o, 0);
    cmt_v_i = 1'b1; cyc(); cyc(); cyc(); idle();
    chk("t1_drained", total_cnt_o, 0);

    // fill to full; a same-cycle commit must not free space
    enq(8'h01); enq(8'h02); enq(8'h03); enq(8'h04);
    chk("t2_full_total", total_cnt_o, 4);
    enq_v_i = 1'b1; enq_data_i = 8'h05; #1;
    chk("t2_full_ready", enq_ready_o, 0);
    cyc(); idle();
    chk("t2_hold_total", total_cnt_o, 4);
    issue_yumi_i = 1'b1; chk("t2_iss", issue_data_o, 8'h01); cyc(); idle();
    cmt_v_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 8'h55; #1;
    chk("t2_cmt_ready", enq_ready_o, 0);
    cyc(); idle();
    chk("t2_ready_after", enq_ready_o, 1);
    chk("t2_total_after", total_cnt_o, 3);
    chk("t2_issued_after", issued_cnt_o, 0);
    chk("t2_head", issue_data_o, 8'h02);
    clear();
    chk("t2_clr_total", total_cnt_o, 0);

    // roll with concurrent yumi: the yumi is dropped
    enq(8'h0A); enq(8'h0B); enq(8'h0C); enq(8'h0D);
    issue_yumi_i = 1'b1; cyc(); cyc(); cyc(); idle();
    cmt_v_i = 1'b1; cyc(); idle();
    chk("t3_issued_pre", issued_cnt_o, 2);
    roll_v_i = 1'b1; issue_yumi_i = 1'b1; cyc(); idle();
    chk("t3_roll_d", issue_data_o, 8'h0B);
    chk("t3_roll_issued", issued_cnt_o, 0);
    chk("t3_roll_total", total_cnt_o, 3);
    clear();

    // roll together with commit
    enq(8'h0A); enq(8'h0B);
    issue_yumi_i = 1'b1; cyc(); cyc(); idle();
    roll_v_i = 1'b1; cmt_v_i = 1'b1; cyc(); idle();
    chk("t4_v", issue_v_o, 1);
    chk("t4_d", issue_data_o, 8'h0B);
    chk("t4_issued", issued_cnt_o, 0);
    chk("t4_total", total_cnt_o, 1);
    clear();

    // pointer wrap: ten single-entry round trips
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] d;
      d = DW'(8'h10 + i);
      enq(d);
      chk("t5_d", issue_data_o, d);
      chk("t5_total", total_cnt_o, 1);
      chk("t5_ready", enq_ready_o, 1);
      issue_yumi_i = 1'b1; cyc(); idle();
      chk("t5_issued", issued_cnt_o, 1);
      cmt_v_i = 1'b1; cyc(); idle();
      chk("t5_total0", total_cnt_o, 0);
    end

    // clear discards a concurrent enqueue
    enq(8'h61); enq(8'h62); enq(8'h63);
    clr_v_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 8'h77; #1;
    chk("t6_ready_same", enq_ready_o, 1);
    cyc(); idle();
    chk("t6_v", issue_v_o, 0);
    chk("t6_total", total_cnt_o, 0);
    chk("t6_ready", enq_ready_o, 1);
    cyc();
    chk("t6_total_later", total_cnt_o, 0);

    // asynchronous reset between clock edges
    enq(8'h81); enq(8'h82);
    issue_yumi_i = 1'b1; cyc(); idle();
    chk("t7_pre_total", total_cnt_o, 2);
    #2 reset_n_i = 1'b0;
    #1;
    chk("t7_v", issue_v_o, 0);
    chk("t7_total", total_cnt_o, 0);
    chk("t7_issued", issued_cnt_o, 0);
    chk("t7_ready", enq_ready_o, 1);
    #1 reset_n_i = 1'b1;
    cyc();
    chk("t7_v_after", issue_v_o, 0);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    // bypass with same-cycle yumi keeps the entry rollable
    enq_v_i = 1'b1; enq_data_i = 8'h05; issue_yumi_i = 1'b1; #1;
    chk("t8_byp_v", issue_v_o, 1);
    chk("t8_byp_d", issue_data_o, 8'h05);
    cyc(); idle();
    chk("t8_issued", issued_cnt_o, 1);
    chk("t8_total", total_cnt_o, 1);
    roll_v_i = 1'b1; cyc(); idle();
    chk("t8_roll_d", issue_data_o, 8'h05);
`else
    enq_v_i = 1'b1; enq_data_i = 8'h05; #1;
    chk("t8_nobyp_v", issue_v_o, 0);
    cyc(); idle();
    chk("t8_v", issue_v_o, 1);
    chk("t8_d", issue_data_o, 8'h05);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
